// File: rtl/pipe_pulse_chain.sv
`default_nettype none
// ============================================================================
// Module : pipe_pulse_chain
// Multi-channel edge-triggered pulse stretcher with a per-channel delay line.
// Rev    : 1.0
// ============================================================================
module pipe_pulse_chain #(
  parameter int CH        = 4,
  parameter int DEPTH     = 2,
  parameter int PULSE_LEN = 1,
  parameter int EDGE      = 0,
  parameter int CASCADE   = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] s,
  input  logic [CH-1:0] pipe_in,
  input  logic [CH-1:0] en,
  input  logic          clear,
  output logic [CH-1:0] pipe_out,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] retrig
);

  localparam logic [7:0] C_PULSE_LEN = 8'(PULSE_LEN);

  logic [CH-1:0] casc;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic             s_prev_q, s_prev_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [DEPTH-1:0] dl_q, dl_d;
    logic             retrig_q, retrig_d;
    logic             edge_det;
    logic             trig;

    if (CASCADE != 0 && i > 0) begin : g_casc
      assign casc[i] = pipe_out[i-1];
    end else begin : g_no_casc
      assign casc[i] = 1'b0;
    end

    always_comb begin
      s_prev_d = s[i];
      case (EDGE)
        0:       edge_det = s[i] & ~s_prev_q;
        1:       edge_det = ~s[i] & s_prev_q;
        default: edge_det = s[i] ^ s_prev_q;
      endcase
      trig = en[i] & (edge_det | pipe_in[i] | casc[i]);

      // A retrigger reloads the counter, so overlapping pulses merge.
      if (trig) begin
        cnt_d = C_PULSE_LEN;
      end else if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        cnt_d = cnt_q;
      end

      dl_d    = '0;
      dl_d[0] = trig | (cnt_q > 8'd1);
      for (int k = 1; k < DEPTH; k++) begin
        dl_d[k] = dl_q[k-1];
      end

      // Setting takes priority over a coincident clear.
      retrig_d = (trig & (cnt_q != 8'd0)) | (retrig_q & ~clear);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s_prev_q <= 1'b0;
        cnt_q    <= 8'd0;
        dl_q     <= '0;
        retrig_q <= 1'b0;
      end else begin
        s_prev_q <= s_prev_d;
        cnt_q    <= cnt_d;
        dl_q     <= dl_d;
        retrig_q <= retrig_d;
      end
    end

    assign pipe_out[i] = dl_q[DEPTH-1];
    assign busy[i]     = (cnt_q != 8'd0);
    assign retrig[i]   = retrig_q;
  end

endmodule
`default_nettype wire
